// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall/flush sequencer.
// Covers Tuse/Tnew values, mult/div latencies and the HI/LO timer states.
package pipe_ctrl_pkg;

    localparam logic [1:0] TUSE_0     = 2'd0;
    localparam logic [1:0] TUSE_1     = 2'd1;
    localparam logic [1:0] TUSE_2     = 2'd2;
    localparam logic [1:0] TUSE_NEVER = 2'd3;

    localparam logic [1:0] TNEW_0     = 2'd0;
    localparam logic [1:0] TNEW_1     = 2'd1;
    localparam logic [1:0] TNEW_2     = 2'd2;
    localparam logic [1:0] TNEW_NEVER = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and stall/flush controls between the D-stage decode and the stall sequencer.
// The master modport belongs to the pipeline, the slave modport to pipe_stall_ctrl.
interface pipe_stall_ctrl_if;

    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_rs_tuse;
    logic [1:0]  D_rt_tuse;
    logic        D_is_md;
    logic [4:0]  E_wa;
    logic [1:0]  E_tnew;
    logic [4:0]  M_wa;
    logic [1:0]  M_tnew;
    logic        E_md_start;
    logic        E_md_div;
    logic        exc_req;

    logic        F_en;
    logic        D_en;
    logic        E_clr;
    logic        req;
    logic        md_busy;
    logic        stall;
    logic [31:0] perf_stall;
    logic [31:0] perf_md;

    modport master (
        output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
               E_wa, E_tnew, M_wa, M_tnew,
               E_md_start, E_md_div, exc_req,
        input  F_en, D_en, E_clr, req, md_busy, stall, perf_stall, perf_md
    );

    modport slave (
        input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
               E_wa, E_tnew, M_wa, M_tnew,
               E_md_start, E_md_div, exc_req,
        output F_en, D_en, E_clr, req, md_busy, stall, perf_stall, perf_md
    );

endinterface

// File: rtl/pipe_stall_ctrl_md_busy_timer.sv
// HI/LO busy timer: models mult/div latency with an IDLE/BUSY FSM and a down-counter.
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic flush,
    output logic busy
);

    md_state_t        state;
    logic [CNT_W-1:0] count;

    // A flushed mult/div never loads; once loaded the count runs to zero even across exceptions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            count <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start && !flush) begin
                        count <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state <= MD_BUSY;
                        busy  <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end
                    if (count <= CNT_W'(1)) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Tuse/Tnew hazards, mult/div occupancy, exceptions.
// Optional stall performance counters are built when PERF_CNT_EN is defined.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stall_ctrl_if.slave  bus
);

    logic timer_busy;
    logic hz_rs;
    logic hz_rt;
    logic md_stall;
    logic stall_int;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (bus.E_md_start),
        .is_div (bus.E_md_div),
        .flush  (bus.exc_req),
        .busy   (timer_busy)
    );

    // $0 is hardwired, so a match on register zero is never a hazard.
    always_comb begin
        hz_rs = (bus.D_rs != 5'd0) &&
                (((bus.D_rs == bus.E_wa) && (bus.D_rs_tuse < bus.E_tnew)) ||
                 ((bus.D_rs == bus.M_wa) && (bus.D_rs_tuse < bus.M_tnew)));
        hz_rt = (bus.D_rt != 5'd0) &&
                (((bus.D_rt == bus.E_wa) && (bus.D_rt_tuse < bus.E_tnew)) ||
                 ((bus.D_rt == bus.M_wa) && (bus.D_rt_tuse < bus.M_tnew)));
    end

    assign bus.md_busy = timer_busy | bus.E_md_start;
    assign md_stall    = bus.D_is_md & bus.md_busy;

    // An exception flushes everything, so it always wins over a pending stall.
    assign stall_int = (hz_rs | hz_rt | md_stall) & ~bus.exc_req;
    assign bus.stall = stall_int;
    assign bus.F_en  = ~stall_int;
    assign bus.D_en  = ~stall_int;
    assign bus.E_clr = stall_int;
    assign bus.req   = bus.exc_req;

`ifdef PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_md_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_md_q    <= '0;
        end else begin
            if (stall_int) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (md_stall && !bus.exc_req) begin
                perf_md_q <= perf_md_q + 32'd1;
            end
        end
    end

    assign bus.perf_stall = perf_stall_q;
    assign bus.perf_md    = perf_md_q;
`else
    assign bus.perf_stall = 32'd0;
    assign bus.perf_md    = 32'd0;
`endif

endmodule
